// File: rtl/digit_serial_subtractor.sv
// Digit-serial ripple-borrow subtractor: diff = (a - b - bin) mod 2^SIZE, one DIGIT-bit digit per
// clock, LSB digit first, with valid/ready handshakes on operands and result.
module digit_serial_subtractor #(
  parameter int unsigned SIZE  = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            bin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] diff,
  output logic            bout,
  output logic            ovf
);

  localparam int unsigned N    = SIZE / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [SIZE-1:0]   a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              borrow_q, borrow_d, bout_q, bout_d, ovf_q, ovf_d;

  logic [31:0]       base;
  logic [DIGIT-1:0]  a_dig, b_dig;
  logic [DIGIT:0]    sub_full;
  logic              msb_borrow;

  assign base     = 32'(cnt_q) * DIGIT;
  assign a_dig    = a_q[base +: DIGIT];
  assign b_dig    = b_q[base +: DIGIT];
  assign sub_full = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, borrow_q};
  // Sum bit = a ^ b ^ borrow-in, so the borrow into the MSB falls out of the result bit.
  assign msb_borrow = sub_full[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          diff_d   = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        diff_d[base +: DIGIT] = sub_full[DIGIT-1:0];
        borrow_d              = sub_full[DIGIT];
        cnt_d                 = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          bout_d  = sub_full[DIGIT];
          ovf_d   = msb_borrow ^ sub_full[DIGIT];
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Directed bench for digit_serial_subtractor (SIZE=16, DIGIT=4) with hand-computed results.
module tb_digit_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, bin, out_valid, out_ready, bout, ovf;
  logic [15:0] a, b, diff;

  int n_tests = 0;
  int n_fail  = 0;

  digit_serial_subtractor #(.SIZE(16), .DIGIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one operand pair, wait for the result, check it and the latency, then drain it.
  task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic bv_in, input logic [15:0] ed, input logic eb, input logic eo);
    int lat;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a = av; b = bv; bin = bv_in; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = ~av; b = ~bv; bin = ~bv_in;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd4);
    chk({tag, ".diff"}, 32'(diff), 32'(ed));
    chk({tag, ".bout"}, 32'(bout), 32'(eb));
    chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".drained"}, 32'(out_valid), 32'd0);
  endtask

  logic [15:0] bb_a [3];
  logic [15:0] bb_b [3];
  logic [15:0] bb_d [3];
  int          acc_cyc [3];

  initial begin
    int nacc, nres, cyc;
    logic just_acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    step();
    step();
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.diff", 32'(diff), 32'd0);
    chk("rst.bout", 32'(bout), 32'd0);
    chk("rst.ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle.in_ready", 32'(in_ready), 32'd1);

    do_op("v0", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    do_op("v1", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    do_op("v2", 16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    do_op("v3", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
    do_op("v4", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    do_op("v5", 16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("v6", 16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0);

    // Backpressure: stray in_valid pulses during RUN/DONE must not be taken.
    a = 16'h0010; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
    step();
    a = 16'h5555; b = 16'h1111;
    for (int i = 0; i < 4; i++) begin
      chk("bp.run_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp.out_valid", 32'(out_valid), 32'd1);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      chk("bp.diff", 32'(diff), 32'h000F);
      chk("bp.bout_ovf", 32'({bout, ovf}), 32'd0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp.drop", 32'(out_valid), 32'd0);
    chk("bp.diff_kept", 32'(diff), 32'h000F);
    chk("bp.in_ready_back", 32'(in_ready), 32'd1);

    // Reset mid-operation, asserted on the edge after cnt reaches 1.
    a = 16'h4321; b = 16'h1234; bin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("mid.out_valid", 32'(out_valid), 32'd0);
    chk("mid.diff", 32'(diff), 32'd0);
    chk("mid.in_ready_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid.in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) step();
    chk("mid.no_result", 32'(out_valid), 32'd0);
    do_op("mid.after", 16'h4321, 16'h1234, 1'b0, 16'h30ED, 1'b0, 1'b0);

    // Back-to-back with in_valid and out_ready held high.
    bb_a[0] = 16'h0000; bb_b[0] = 16'h0001; bb_d[0] = 16'hFFFF;
    bb_a[1] = 16'h0005; bb_b[1] = 16'h0003; bb_d[1] = 16'h0002;
    bb_a[2] = 16'hABCD; bb_b[2] = 16'h1234; bb_d[2] = 16'h9999;
    nacc = 0; nres = 0; cyc = 0; just_acc = 1'b0;
    a = bb_a[0]; b = bb_b[0]; bin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    while (nres < 3 && cyc < 40) begin
      if (just_acc && nacc < 3) begin
        a = bb_a[nacc]; b = bb_b[nacc];
      end
      just_acc = 1'b0;
      if (in_ready && nacc < 3) begin
        acc_cyc[nacc] = cyc;
        nacc++;
        just_acc = 1'b1;
      end
      if (out_valid) begin
        chk($sformatf("b2b.diff%0d", nres), 32'(diff), 32'(bb_d[nres]));
        nres++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b.results", 32'(nres), 32'd3);
    chk("b2b.accepts", 32'(nacc), 32'd3);
    chk("b2b.gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
    chk("b2b.gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
